load_hazard_ctrl: RTL

Decode-stage hazard controller for the 5-stage MIPS pipeline. It drives the `LOADDEPEN` stall that freezes the PC register and the IF/ID register. It tracks the destination register and type of the instructions in flight in EX and MEM in its own shadow registers, detects load-use and (optionally) RAW dependencies for the instruction in ID, and injects a bubble into ID/EX. It also generates the ID-stage forwarding selects and keeps a saturating stall counter.

---
 rtl/load_hazard_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/load_hazard_ctrl.sv
// Decode-stage load/RAW hazard controller with EX/MEM shadow slots, ID forwarding selects and a stall counter.
// Optional macro LOAD_HAZARD_ID_FWD_EN: enables ID forwarding so that only load-use hazards stall.
module load_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_rn,
  output logic             LOADDEPEN,
  output logic             bubble,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [CNT_W-1:0] stall_cnt
);

  logic       r_e_wreg;
  logic       r_e_m2reg;
  logic [4:0] r_e_rn;
  logic       r_m_wreg;
  logic       r_m_m2reg;
  logic [4:0] r_m_rn;

  logic w_e_rs;
  logic w_e_rt;
  logic w_m_rs;
  logic w_m_rt;
  logic w_stall;

  // Hits already fold in the "source is actually read" qualifier and the r0 exclusion.
  assign w_e_rs = id_use_rs && r_e_wreg && (r_e_rn != 5'd0) && (r_e_rn == id_rs);
  assign w_e_rt = id_use_rt && r_e_wreg && (r_e_rn != 5'd0) && (r_e_rn == id_rt);
  assign w_m_rs = id_use_rs && r_m_wreg && (r_m_rn != 5'd0) && (r_m_rn == id_rs);
  assign w_m_rt = id_use_rt && r_m_wreg && (r_m_rn != 5'd0) && (r_m_rn == id_rt);

`ifdef LOAD_HAZARD_ID_FWD_EN
  function automatic logic [1:0] f_sel(input logic e_hit, input logic e_ld,
                                       input logic m_hit, input logic m_ld);
    if (e_hit && !e_ld)      return 2'b01;
    else if (m_hit && !m_ld) return 2'b10;
    else if (m_hit)          return 2'b11;
    else                     return 2'b00;
  endfunction

  assign w_stall = id_valid && r_e_m2reg && (w_e_rs || w_e_rt);

  always_comb begin
    fwda = 2'b00;
    fwdb = 2'b00;
    if (!clr) begin
      fwda = f_sel(w_e_rs, r_e_m2reg, w_m_rs, r_m_m2reg);
      fwdb = f_sel(w_e_rt, r_e_m2reg, w_m_rt, r_m_m2reg);
    end
  end
`else
  logic w_unused_m2reg;

  // Without forwarding the load flag in MEM carries no information.
  assign w_unused_m2reg = r_m_m2reg;
  assign w_stall = id_valid && (w_e_rs || w_e_rt || w_m_rs || w_m_rt);
  assign fwda    = 2'b00;
  assign fwdb    = 2'b00;
`endif

  assign LOADDEPEN = w_stall && !clr;
  assign bubble    = LOADDEPEN;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_e_wreg  <= 1'b0;
      r_e_m2reg <= 1'b0;
      r_e_rn    <= 5'd0;
      r_m_wreg  <= 1'b0;
      r_m_m2reg <= 1'b0;
      r_m_rn    <= 5'd0;
    end else begin
      r_m_wreg  <= r_e_wreg;
      r_m_m2reg <= r_e_m2reg;
      r_m_rn    <= r_e_rn;
      if (id_valid && !bubble) begin
        r_e_wreg  <= id_wreg;
        r_e_m2reg <= id_m2reg;
        r_e_rn    <= id_rn;
      end else begin
        r_e_wreg  <= 1'b0;
        r_e_m2reg <= 1'b0;
        r_e_rn    <= 5'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (LOADDEPEN && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
